// File: rtl/rv32i_types.sv
// Shared RV32I load/store types: controller states, response codes, funct3 encodings
// and the store-side lane helpers.
package rv32i_types;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    ErrOk         = 2'b00,
    ErrMisaligned = 2'b01,
    ErrTimeout    = 2'b10,
    ErrIllegal    = 2'b11
  } rsp_err_e;

  typedef enum logic [2:0] {
    LdB  = 3'b000,
    LdH  = 3'b001,
    LdW  = 3'b010,
    LdBu = 3'b100,
    LdHu = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    SdB = 3'b000,
    SdH = 3'b001,
    SdW = 3'b010
  } store_funct3_e;

  function automatic logic f3_legal(logic we, logic [2:0] f3);
    if (we) return f3 inside {SdB, SdH, SdW};
    return f3 inside {LdB, LdH, LdW, LdBu, LdHu};
  endfunction

  // funct3[1:0] encodes the access size for every legal load and store.
  function automatic logic f3_misaligned(logic [2:0] f3, logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(logic [2:0] f3, logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(logic [2:0] f3, logic [31:0] wdata);
    case (f3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it according to funct3.
module load_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    result  = '0;
    case (funct3)
      LdB:     result = {{24{shifted[7]}}, shifted[7:0]};
      LdH:     result = {{16{shifted[15]}}, shifted[15:0]};
      LdW:     result = shifted;
      LdBu:    result = {24'b0, shifted[7:0]};
      LdHu:    result = {16'b0, shifted[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: drives a word-addressed memory port with byte enables,
// aligns load data and guards each access with a watchdog.
module lsu_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYCLES);

  lsu_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    off_q, off_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  rsp_err_e      err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          req_illegal, req_misaligned;
  logic [31:0]   load_result;

  assign req_illegal    = !f3_legal(req_we, req_funct3);
  assign req_misaligned = f3_misaligned(req_funct3, req_addr[1:0]);

  load_align u_load_align (
    .funct3 (funct3_q),
    .offset (off_q),
    .word   (mem_rdata),
    .result (load_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = (req_illegal || req_misaligned) ? StDone : StAccess;
      StAccess: if (mem_resp || cnt_q == CntLast) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = state_q == StIdle;
    mem_read  = (state_q == StAccess) && !we_q;
    mem_write = (state_q == StAccess) && we_q;
    rsp_valid = state_q == StDone;
  end

  assign rsp_rdata       = rdata_q;
  assign rsp_err         = err_q;
  assign mem_address     = addr_q;
  assign mem_byte_enable = be_q;
  assign mem_wdata       = wdata_q;

  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          addr_d   = {req_addr[31:2], 2'b00};
          be_d     = byte_en(req_funct3, req_addr[1:0]);
          wdata_d  = store_data(req_funct3, req_wdata);
          cnt_d    = '0;
          rdata_d  = '0;
          // Illegal funct3 takes precedence: its size, and so its alignment, is undefined.
          if (req_illegal)         err_d = ErrIllegal;
          else if (req_misaligned) err_d = ErrMisaligned;
          else                     err_d = ErrOk;
        end
      end
      StAccess: begin
        // A response in the final watchdog cycle still completes normally.
        if (mem_resp) begin
          rdata_d = we_q ? '0 : load_result;
          err_d   = ErrOk;
        end else if (cnt_q == CntLast) begin
          rdata_d = '0;
          err_d   = ErrTimeout;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      err_q    <= ErrOk;
      rdata_q  <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed corner cases then random requests checked against a
// byte-level reference model of RV32I load/store semantics.
module tb_lsu_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int checks = 0;
  int passed = 0;

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // ---- reference model ----
  function automatic int unsigned acc_size(logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [1:0] model_err(logic we, logic [2:0] f3, logic [31:0] addr);
    logic legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 2'b11;
    if ((int'(addr[1:0]) % acc_size(f3)) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] f3, logic [1:0] off);
    logic [3:0] be = '0;
    for (int i = 0; i < int'(acc_size(f3)); i++) be[int'(off) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] wd);
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = wd[8*(i % int'(acc_size(f3))) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] model_rdata(logic [2:0] f3, logic [1:0] off,
                                              logic [31:0] word);
    logic [31:0] v = '0;
    int sz = int'(acc_size(f3));
    for (int i = 0; i < sz; i++) v[8*i +: 8] = word[8*(int'(off) + i) +: 8];
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1])
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // resp_at: strobe cycle (1-based) carrying mem_resp; 0 or >TO means never.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int resp_at);
    logic [1:0]  e;
    logic        responded;
    logic [1:0]  exp_err;
    logic [31:0] exp_rd;
    e = model_err(we, f3, addr);
    responded = (e == 2'b00) && resp_at >= 1 && resp_at <= int'(TO);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    if (e == 2'b00) begin
      for (int k = 1; k <= int'(TO); k++) begin
        chk({tag, " mem_read"}, 32'(mem_read), 32'(!we));
        chk({tag, " mem_write"}, 32'(mem_write), 32'(we));
        chk({tag, " address"}, mem_address, {addr[31:2], 2'b00});
        chk({tag, " be"}, 32'(mem_byte_enable), 32'(model_be(f3, addr[1:0])));
        if (we) chk({tag, " wdata"}, mem_wdata, model_wdata(f3, wd));
        chk({tag, " early rsp_valid"}, 32'(rsp_valid), 32'd0);
        if (k == resp_at) begin mem_resp = 1'b1; mem_rdata = rd; end
        else mem_rdata = $urandom;
        @(negedge clk);
        mem_resp = 1'b0;
        if (k == resp_at) break;
      end
    end
    exp_err = (e != 2'b00) ? e : (responded ? 2'b00 : 2'b10);
    exp_rd  = (responded && !we) ? model_rdata(f3, addr[1:0], rd) : 32'd0;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " strobes"}, 32'({mem_read, mem_write}), 32'd0);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({tag, " rsp_rdata"}, rsp_rdata, exp_rd);
    @(negedge clk);
    chk({tag, " rsp_valid pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset be", 32'(mem_byte_enable), 32'd0);
    chk("reset address", mem_address, 32'd0);
    chk("reset wdata", mem_wdata, 32'd0);
    chk("reset ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_req("lw 1000", 1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEADBEEF, 3);
    run_req("lb 1003", 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80112233, 1);
    run_req("lbu 1003", 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80112233, 2);
    run_req("sh 2002", 1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 32'h12345678, 1);
    run_req("lw misaligned", 1'b0, 3'b010, 32'h1001, 32'h0, 32'h0, 1);
    run_req("illegal f3", 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 1);
    run_req("timeout", 1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 0);
    run_req("resp on last", 1'b0, 3'b101, 32'h4002, 32'h0, 32'hBEEF8001, int'(TO));

    // mem_resp outside ACCESS must not start or complete anything
    mem_resp = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("idle resp rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle resp ready", 32'(req_ready), 32'd1);
    chk("idle resp strobes", 32'({mem_read, mem_write}), 32'd0);

    // reset in the middle of an access
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort mem_read", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort address", mem_address, 32'd0);
    chk("abort ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("abort no late rsp", 32'(rsp_valid), 32'd0);
    chk("abort ready next", 32'(req_ready), 32'd1);

    for (int n = 0; n < 150; n++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_req("random", we, f3, addr, $urandom, $urandom, int'($urandom_range(0, 5)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
